axi_slave_ram: RTL and testbench

AXI_SLAVE_RAM -- requirements
Module: axi_slave_ram
Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, data bus width in bits (32 or 64).
REQ-002 SHALL have parameter C_OFFSET_WIDTH, default 28, byte-address width.
REQ-003 SHALL have parameter C_DEPTH_LOG2, default 12, log2 of the number of data-width words stored.
REQ-004 SHALL have port ACLK  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port ARESETN  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port AWADDR  input  C_OFFSET_WIDTH  write burst start byte address.
REQ-007 SHALL have port AWLEN  input  8  write beats minus 1.
REQ-008 SHALL have port AWVALID/AWREADY  input/output  1/1  write-address handshake.
REQ-009 SHALL have port WDATA  input  C_AXI_DATA_WIDTH  write data.
REQ-010 SHALL have port WSTRB  input  C_AXI_DATA_WIDTH/8  byte enables.
REQ-011 SHALL have port WLAST  input  1  final write beat marker.
REQ-012 SHALL have port WVALID/WREADY  input/output  1/1  write-data handshake.
REQ-013 SHALL have port BRESP  output  2  write response.
REQ-014 SHALL have port BVALID/BREADY  output/input  1/1  write-response handshake.
REQ-015 SHALL have port ARADDR  input  C_OFFSET_WIDTH  read burst start byte address.
REQ-016 SHALL have port ARLEN  input  8  read beats minus 1.
REQ-017 SHALL have port ARVALID/ARREADY  input/output  1/1  read-address handshake.
REQ-018 SHALL have port RDATA  output  C_AXI_DATA_WIDTH  read data, registered.
REQ-019 SHALL have port RRESP  output  2  read response.
REQ-020 SHALL have port RLAST  output  1  final read beat marker.
REQ-021 SHALL have port RVALID/RREADY  output/input  1/1  read-data handshake.
Function
REQ-022 SHALL support INCR bursts of full-width beats only; word index = address[C_DEPTH_LOG2+log2(C_AXI_DATA_WIDTH/8)-1 : log2(C_AXI_DATA_WIDTH/8)], low bits ignored, upper bits ignored, index increments per beat and wraps modulo 2^C_DEPTH_LOG2.
REQ-023 Write FSM SHALL be W_IDLE (AWREADY=1) -> W_DATA on AW handshake (AWREADY=0, WREADY=1) -> W_RESP after beat AWLEN+1 accepted (WREADY=0, BVALID=1 next cycle) -> W_IDLE on BVALID&BREADY.
REQ-024 Each accepted W beat SHALL update only bytes with WSTRB=1; burst length SHALL be counted from AWLEN, WLAST ignored (early/late WLAST does not change beat count).
REQ-025 Read FSM SHALL be R_IDLE (ARREADY=1) -> R_DATA on AR handshake; first RVALID exactly 1 cycle after AR handshake; each beat advances only on RVALID&RREADY; RLAST=1 on beat ARLEN; R_IDLE after last-beat handshake.
REQ-026 RDATA/RLAST SHALL stay stable while RVALID=1 and RREADY=0.
REQ-027 Read and write FSMs SHALL run concurrently; same-word same-cycle read and write SHALL return old data (read-before-write).
REQ-028 BRESP and RRESP SHALL always be 2'b00 (OKAY); no outstanding-transaction queuing (one burst per channel at a time).
Reset
REQ-029 With ARESETN=0 at a rising edge: both FSMs idle; AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST=0; RDATA=0; BRESP/RRESP=0; AWREADY/ARREADY=1 from the first cycle after release.
REQ-030 Reset mid-burst SHALL abort the burst silently; already-written beats remain; memory array is never reset.
Configuration
REQ-031 Macro AXI_SLAVE_RAM_WAIT_EN defined: read FSM SHALL insert state R_WAIT of exactly 4 cycles between AR handshake and the first RVALID, and 1 cycle with WREADY=0 after every accepted W beat, for core stall testing.
REQ-032 Macro undefined: no R_WAIT state, no write gaps, timing per REQ-023/025.
Structure
REQ-033 Package axi_slave_ram_pkg SHALL hold FSM state typedefs, RESP_OKAY, WAIT_CYCLES (4) and the byte-offset-width function.
REQ-034 Storage SHALL be sub-module axi_slave_ram_mem: simple dual-port, byte-enable write port, synchronous read port.
Verification
REQ-035 Write AWADDR=0x10, AWLEN=3, data 0x11..0x44, WSTRB=F -> BVALID 1 cycle after 4th beat, BRESP=0; read back ARADDR=0x10, ARLEN=3 -> 0x11,0x22,0x33,0x44, RLAST on 4th.
REQ-036 Write 0xAABBCCDD with WSTRB=0x5 over 0x00000000 -> read 0x00BB00DD.
REQ-037 C_DEPTH_LOG2=4, write AWADDR=0x3C, AWLEN=1 -> second beat lands at word 0 (wrap).
REQ-038 Read burst ARLEN=2 with RREADY low for 3 cycles on beat 1 -> RDATA stable, no beat lost; with AXI_SLAVE_RAM_WAIT_EN first RVALID 5 cycles after AR handshake.
REQ-039 ARESETN low for 1 cycle during write beat 2 of AWLEN=3 -> all outputs at reset values, AWREADY=1 next cycle, beats 0-1 retained in memory.

---
 rtl/axi_slave_ram_pkg.sv | 28 ++
 rtl/axi_slave_ram_mem.sv | 45 ++++
 rtl/axi_slave_ram.sv | 277 +++++++++++++++++++++++++++
 tb/tb_axi_slave_ram.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_ram_pkg.sv
// Shared definitions for the AXI slave RAM: FSM state encodings, response
// code, wait-mode stall length and the byte-offset width helper.
// Optional feature macro: AXI_SLAVE_RAM_WAIT_EN (adds read/write stalls).
package axi_slave_ram_pkg;

  // Write channel FSM encoding
  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE = 2'd0;
  localparam w_state_t W_DATA = 2'd1;
  localparam w_state_t W_RESP = 2'd2;

  // Read channel FSM encoding (R_WAIT is only reachable in wait mode)
  typedef logic [1:0] r_state_t;
  localparam r_state_t R_IDLE = 2'd0;
  localparam r_state_t R_WAIT = 2'd1;
  localparam r_state_t R_DATA = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Idle cycles between AR handshake and first RVALID in wait mode
  localparam int WAIT_CYCLES = 4;

  // Number of address bits that select a byte within one data word
  function automatic int byte_off_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_slave_ram_mem.sv
// Simple dual-port storage for the AXI slave RAM: one byte-enable write
// port and one synchronous read port. A read and a write to the same word
// in the same cycle return the old contents. The array itself is never
// reset; only the read-data register is cleared.
module axi_slave_ram_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_re,
  input  logic [ADDR_W-1:0]   i_raddr,
  output logic [DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Byte-masked write: only lanes with a set strobe are updated
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read; holds its value when no read is requested
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_slave_ram.sv
// AXI slave RAM: INCR bursts of full-width beats into a word-addressed
// memory. Independent read and write FSMs, one burst per channel at a time,
// responses always OKAY. Word index comes from the address bits just above
// the byte offset and wraps at the memory depth.
// Optional feature macro: AXI_SLAVE_RAM_WAIT_EN -- read FSM waits
// WAIT_CYCLES before the first beat and WREADY drops for one cycle after
// every accepted write beat.
//
// Handshakes: a transfer happens on a rising ACLK edge where both VALID and
// READY are high; VALID sources hold payload stable until that edge, and
// READY never depends combinationally on VALID (all READY/VALID outputs
// here are registers).
module axi_slave_ram
  import axi_slave_ram_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 28,
  parameter int C_DEPTH_LOG2     = 12
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  // Write address channel
  input  logic [C_OFFSET_WIDTH-1:0]     AWADDR,
  input  logic [7:0]                    AWLEN,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  // Write data channel
  input  logic [C_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                          WLAST,
  input  logic                          WVALID,
  output logic                          WREADY,
  // Write response channel
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  // Read address channel
  input  logic [C_OFFSET_WIDTH-1:0]     ARADDR,
  input  logic [7:0]                    ARLEN,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  // Read data channel
  output logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RLAST,
  output logic                          RVALID,
  input  logic                          RREADY,
  // FSM state visibility
  output logic [1:0]                    o_dbg_wstate,
  output logic [1:0]                    o_dbg_rstate
);

  localparam int BOFF = byte_off_width(C_AXI_DATA_WIDTH);
  localparam logic [C_DEPTH_LOG2-1:0] IDX_ONE = 1;

`ifdef AXI_SLAVE_RAM_WAIT_EN
  // A one-cycle WREADY gap follows every accepted beat
  localparam logic W_READY_AFTER_BEAT = 1'b0;
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);
`else
  localparam logic W_READY_AFTER_BEAT = 1'b1;
`endif

  // Write channel state
  w_state_t                r_wstate;
  logic                    r_awready;
  logic                    r_wready;
  logic                    r_bvalid;
  logic [C_DEPTH_LOG2-1:0] r_widx;
  logic [7:0]              r_wlen;
  logic [7:0]              r_wbeat;

  // Read channel state
  r_state_t                r_rstate;
  logic                    r_arready;
  logic                    r_rvalid;
  logic                    r_rlast;
  logic [C_DEPTH_LOG2-1:0] r_ridx;
  logic [7:0]              r_rlen;
  logic [7:0]              r_rbeat;
`ifdef AXI_SLAVE_RAM_WAIT_EN
  logic [2:0]              r_wait_cnt;
`endif

  logic [C_DEPTH_LOG2-1:0]     w_aw_idx;
  logic [C_DEPTH_LOG2-1:0]     w_ar_idx;
  logic                        w_wfire;
  logic                        w_mem_we;
  logic                        w_mem_re;
  logic [C_DEPTH_LOG2-1:0]     w_mem_raddr;
  logic [C_AXI_DATA_WIDTH-1:0] w_mem_rdata;
  logic                        w_unused;

  // Byte-offset and above-depth address bits plus WLAST carry no meaning
  assign w_unused = ^{AWADDR, ARADDR, WLAST};

  assign w_aw_idx = AWADDR[C_DEPTH_LOG2+BOFF-1 : BOFF];
  assign w_ar_idx = ARADDR[C_DEPTH_LOG2+BOFF-1 : BOFF];

  assign w_wfire  = (r_wstate == W_DATA) && WVALID && r_wready;
  // A beat presented during reset is dropped with the rest of the burst
  assign w_mem_we = w_wfire && ARESETN;

  // Write FSM: address accept, AWLEN+1 data beats, then one response
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wbeat   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (AWVALID && r_awready) begin
            r_wstate  <= W_DATA;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_widx    <= w_aw_idx;
            r_wlen    <= AWLEN;
            r_wbeat   <= '0;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_wfire) begin
            r_widx <= r_widx + IDX_ONE;
            if (r_wbeat == r_wlen) begin
              r_wstate <= W_RESP;
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
            end else begin
              r_wbeat  <= r_wbeat + 8'd1;
              r_wready <= W_READY_AFTER_BEAT;
            end
          end else begin
            r_wready <= 1'b1;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
          end
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: address accept, optional wait, then one beat per R handshake
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
`ifdef AXI_SLAVE_RAM_WAIT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (ARVALID && r_arready) begin
            r_arready <= 1'b0;
            r_ridx    <= w_ar_idx;
            r_rlen    <= ARLEN;
            r_rbeat   <= '0;
`ifdef AXI_SLAVE_RAM_WAIT_EN
            r_rstate   <= R_WAIT;
            r_wait_cnt <= '0;
`else
            r_rstate  <= R_DATA;
            r_rvalid  <= 1'b1;
            r_rlast   <= (ARLEN == 8'd0);
`endif
          end else begin
            r_arready <= 1'b1;
          end
        end
`ifdef AXI_SLAVE_RAM_WAIT_EN
        R_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_rstate <= R_DATA;
            r_rvalid <= 1'b1;
            r_rlast  <= (r_rlen == 8'd0);
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end
`endif
        R_DATA: begin
          if (RREADY) begin
            if (r_rlast) begin
              r_rstate  <= R_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_ridx  <= r_ridx + IDX_ONE;
              r_rbeat <= r_rbeat + 8'd1;
              r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
            end
          end
        end
        default: begin
          r_rstate  <= R_IDLE;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
        end
      endcase
    end
  end

  // Memory read requests: the word for the next visible beat is fetched in
  // the cycle before it must appear on RDATA
  always_comb begin
    w_mem_re    = 1'b0;
    w_mem_raddr = r_ridx + IDX_ONE;
`ifdef AXI_SLAVE_RAM_WAIT_EN
    if ((r_rstate == R_WAIT) && (r_wait_cnt == WAIT_LAST)) begin
      w_mem_re    = 1'b1;
      w_mem_raddr = r_ridx;
    end
`else
    if ((r_rstate == R_IDLE) && ARVALID && r_arready) begin
      w_mem_re    = 1'b1;
      w_mem_raddr = w_ar_idx;
    end
`endif
    if ((r_rstate == R_DATA) && RREADY && !r_rlast) begin
      w_mem_re    = 1'b1;
      w_mem_raddr = r_ridx + IDX_ONE;
    end
  end

  axi_slave_ram_mem #(
    .DATA_W (C_AXI_DATA_WIDTH),
    .ADDR_W (C_DEPTH_LOG2)
  ) u_mem (
    .i_clk   (ACLK),
    .i_rst_n (ARESETN),
    .i_we    (w_mem_we),
    .i_waddr (r_widx),
    .i_wdata (WDATA),
    .i_wstrb (WSTRB),
    .i_re    (w_mem_re),
    .i_raddr (w_mem_raddr),
    .o_rdata (w_mem_rdata)
  );

  assign AWREADY      = r_awready;
  assign WREADY       = r_wready;
  assign BVALID       = r_bvalid;
  assign BRESP        = RESP_OKAY;
  assign ARREADY      = r_arready;
  assign RVALID       = r_rvalid;
  assign RLAST        = r_rlast;
  assign RDATA        = w_mem_rdata;
  assign RRESP        = RESP_OKAY;
  assign o_dbg_wstate = r_wstate;
  assign o_dbg_rstate = r_rstate;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Self-checking bench for axi_slave_ram (32-bit data, 16-word memory).
// Reference model: a plain array of words indexed by (addr/4 + beat) mod 16.
module tb_axi_slave_ram;
  import axi_slave_ram_pkg::*;

  localparam int DW    = 32;
  localparam int OW    = 28;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
`ifdef AXI_SLAVE_RAM_WAIT_EN
  localparam int RD_LAT = 5;
`else
  localparam int RD_LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  logic [OW-1:0]   AWADDR, ARADDR;
  logic [7:0]      AWLEN, ARLEN;
  logic            AWVALID, AWREADY, WLAST, WVALID, WREADY;
  logic [DW-1:0]   WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic [1:0]      BRESP, RRESP;
  logic            BVALID, BREADY, ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [1:0]      dbg_wstate, dbg_rstate;

  axi_slave_ram #(
    .C_AXI_DATA_WIDTH (DW),
    .C_OFFSET_WIDTH   (OW),
    .C_DEPTH_LOG2     (DL)
  ) dut (
    .ACLK (ACLK), .ARESETN (ARESETN),
    .AWADDR (AWADDR), .AWLEN (AWLEN), .AWVALID (AWVALID), .AWREADY (AWREADY),
    .WDATA (WDATA), .WSTRB (WSTRB), .WLAST (WLAST), .WVALID (WVALID), .WREADY (WREADY),
    .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
    .ARADDR (ARADDR), .ARLEN (ARLEN), .ARVALID (ARVALID), .ARREADY (ARREADY),
    .RDATA (RDATA), .RRESP (RRESP), .RLAST (RLAST), .RVALID (RVALID), .RREADY (RREADY),
    .o_dbg_wstate (dbg_wstate), .o_dbg_rstate (dbg_rstate)
  );

  // ---------------- scoreboard / model ----------------
  int            chk_cnt = 0;
  int            err_cnt = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wr_data [256];
  logic [3:0]    wr_strb [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int widx(input logic [OW-1:0] a, input int beat);
    return (int'(a >> 2) + beat) % DEPTH;
  endfunction

  function automatic void model_write(input int idx, input logic [DW-1:0] d, input logic [3:0] s);
    for (int k = 0; k < 4; k++)
      if (s[k]) model_mem[idx][k*8 +: 8] = d[k*8 +: 8];
  endfunction

  // ---------------- driver tasks ----------------
  // Waits until the named ready/valid is seen high, then past the edge that
  // completes the handshake. ch: 0=AWREADY 1=WREADY 2=ARREADY 3=BVALID
  task automatic wait_hs(input int ch);
    int   n;
    logic rdy;
    n = 0;
    forever begin
      @(negedge ACLK);
      case (ch)
        0:       rdy = AWREADY;
        1:       rdy = WREADY;
        2:       rdy = ARREADY;
        default: rdy = BVALID;
      endcase
      if (rdy === 1'b1) break;
      n++;
      if (n >= 100) begin
        check("hs_timeout", 64'(ch) + 64'd1, 64'd0);
        break;
      end
    end
    @(posedge ACLK); #1;
  endtask

  task automatic write_burst(input logic [OW-1:0] addr, input int len,
                             input bit rand_gap, input bit bad_last);
    AWADDR = addr; AWLEN = 8'(len); AWVALID = 1'b1;
    wait_hs(0);
    AWVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (rand_gap) repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
      WDATA = wr_data[b]; WSTRB = wr_strb[b];
      WLAST = bad_last ? (b == 0) : (b == len);
      WVALID = 1'b1;
      wait_hs(1);
      WVALID = 1'b0; WLAST = 1'b0;
      model_write(widx(addr, b), wr_data[b], wr_strb[b]);
    end
    check("b_valid_after_last", 64'(BVALID), 64'd1);
    check("b_resp", 64'(BRESP), 64'(RESP_OKAY));
    check("w_ready_off", 64'(WREADY), 64'd0);
    repeat ($urandom_range(0, 2)) begin
      @(posedge ACLK); #1;
      check("b_hold", 64'(BVALID), 64'd1);
    end
    BREADY = 1'b1;
    wait_hs(3);
    BREADY = 1'b0;
    check("b_done", 64'(BVALID), 64'd0);
    check("aw_ready_back", 64'(AWREADY), 64'd1);
  endtask

  task automatic read_burst(input logic [OW-1:0] addr, input int len,
                            input int stall_beat, input int stall_cyc, input bit rand_stall);
    int            lat;
    int            st;
    logic [DW-1:0] exp;
    for (int b = 0; b <= len; b++) exp_q.push_back(model_mem[widx(addr, b)]);
    ARADDR = addr; ARLEN = 8'(len); ARVALID = 1'b1;
    wait_hs(2);
    ARVALID = 1'b0;
    lat = 1;
    while (RVALID !== 1'b1 && lat < 20) begin @(posedge ACLK); #1; lat++; end
    check("r_first_latency", 64'(lat), 64'(RD_LAT));
    for (int b = 0; b <= len; b++) begin
      exp = exp_q.pop_front();
      st  = rand_stall ? int'($urandom_range(0, 2)) : ((b == stall_beat) ? stall_cyc : 0);
      for (int s = 0; s < st; s++) begin
        check("r_stall_data", 64'(RDATA), 64'(exp));
        check("r_stall_last", 64'(RLAST), 64'(b == len));
        @(posedge ACLK); #1;
      end
      check("r_valid", 64'(RVALID), 64'd1);
      check("r_data", 64'(RDATA), 64'(exp));
      check("r_last", 64'(RLAST), 64'(b == len));
      check("r_resp", 64'(RRESP), 64'(RESP_OKAY));
      RREADY = 1'b1;
      @(posedge ACLK); #1;
      RREADY = 1'b0;
    end
    check("r_done_valid", 64'(RVALID), 64'd0);
    check("r_done_arready", 64'(ARREADY), 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] old_word;
    logic [OW-1:0] ra;
    int            rl;

    ARESETN = 1'b0;
    AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset values
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", 64'(AWREADY), 64'd0);
    check("rst_wready",  64'(WREADY),  64'd0);
    check("rst_bvalid",  64'(BVALID),  64'd0);
    check("rst_arready", 64'(ARREADY), 64'd0);
    check("rst_rvalid",  64'(RVALID),  64'd0);
    check("rst_rlast",   64'(RLAST),   64'd0);
    check("rst_rdata",   64'(RDATA),   64'd0);
    check("rst_dbg_idle", 64'({dbg_wstate, dbg_rstate}), 64'({W_IDLE, R_IDLE}));
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("rel_awready", 64'(AWREADY), 64'd1);
    check("rel_arready", 64'(ARREADY), 64'd1);

    // Clear the whole memory so every later expectation is defined
    for (int b = 0; b < DEPTH; b++) begin wr_data[b] = '0; wr_strb[b] = 4'hF; end
    write_burst('0, DEPTH - 1, 1'b0, 1'b0);

    // Basic 4-beat burst and read-back
    wr_data[0] = 32'h11; wr_data[1] = 32'h22; wr_data[2] = 32'h33; wr_data[3] = 32'h44;
    for (int b = 0; b < 4; b++) wr_strb[b] = 4'hF;
    write_burst(28'h10, 3, 1'b0, 1'b0);
    read_burst(28'h10, 3, -1, 0, 1'b0);

    // Byte strobes over a zero word
    wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'h5;
    write_burst(28'h0, 0, 1'b0, 1'b0);
    read_burst(28'h0, 0, -1, 0, 1'b0);

    // Index wrap at the top of the 16-word memory
    wr_data[0] = 32'h12345678; wr_data[1] = 32'h9ABCDEF0;
    wr_strb[0] = 4'hF;         wr_strb[1] = 4'hF;
    write_burst(28'h3C, 1, 1'b0, 1'b0);
    read_burst(28'h0, 0, -1, 0, 1'b0);
    read_burst(28'h3C, 1, -1, 0, 1'b0);

    // RREADY held low for 3 cycles on beat 1
    read_burst(28'h10, 2, 1, 3, 1'b0);

`ifndef AXI_SLAVE_RAM_WAIT_EN
    // Same word read and written on the same edge returns the old word
    AWADDR = 28'h18; AWLEN = 8'd0; AWVALID = 1'b1;
    wait_hs(0);
    AWVALID = 1'b0;
    old_word = model_mem[6];
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    ARADDR = 28'h18; ARLEN = 8'd0; ARVALID = 1'b1;
    @(negedge ACLK);
    check("rbw_wready",  64'(WREADY),  64'd1);
    check("rbw_arready", 64'(ARREADY), 64'd1);
    @(posedge ACLK); #1;
    WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0;
    model_write(6, 32'hCAFEF00D, 4'hF);
    check("rbw_rvalid",   64'(RVALID), 64'd1);
    check("rbw_old_data", 64'(RDATA),  64'(old_word));
    check("rbw_bvalid",   64'(BVALID), 64'd1);
    RREADY = 1'b1; BREADY = 1'b1;
    @(posedge ACLK); #1;
    RREADY = 1'b0; BREADY = 1'b0;
    read_burst(28'h18, 0, -1, 0, 1'b0);
`endif

    // Randomized bursts: any address bits, gaps, stalls, misplaced WLAST
    for (int it = 0; it < 24; it++) begin
      ra = OW'($urandom());
      rl = int'($urandom_range(0, 7));
      if (it % 2 == 0) begin
        for (int b = 0; b <= rl; b++) begin
          wr_data[b] = $urandom();
          wr_strb[b] = 4'($urandom_range(0, 15));
        end
        write_burst(ra, rl, 1'b1, bit'($urandom_range(0, 1)));
      end else begin
        read_burst(ra, rl, -1, 0, 1'b1);
      end
    end

    // Known non-zero RDATA before the reset test
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
    write_burst(28'h14, 0, 1'b0, 1'b0);
    read_burst(28'h14, 0, -1, 0, 1'b0);

    // Reset pulse while beat 2 of a 4-beat write is offered
    wr_data[0] = 32'hA0A0A0A0; wr_data[1] = 32'hB1B1B1B1; wr_data[2] = 32'hC2C2C2C2;
    AWADDR = 28'h20; AWLEN = 8'd3; AWVALID = 1'b1;
    wait_hs(0);
    AWVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      WDATA = wr_data[b]; WSTRB = 4'hF; WVALID = 1'b1;
      wait_hs(1);
      WVALID = 1'b0;
      model_write(widx(28'h20, b), wr_data[b], 4'hF);
    end
    WDATA = wr_data[2]; WSTRB = 4'hF; WVALID = 1'b1;
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    check("mid_rst_awready", 64'(AWREADY), 64'd0);
    check("mid_rst_wready",  64'(WREADY),  64'd0);
    check("mid_rst_bvalid",  64'(BVALID),  64'd0);
    check("mid_rst_arready", 64'(ARREADY), 64'd0);
    check("mid_rst_rvalid",  64'(RVALID),  64'd0);
    check("mid_rst_rlast",   64'(RLAST),   64'd0);
    check("mid_rst_rdata",   64'(RDATA),   64'd0);
    check("mid_rst_resp",    64'({BRESP, RRESP}), 64'd0);
    ARESETN = 1'b1; WVALID = 1'b0;
    @(posedge ACLK); #1;
    check("mid_rel_awready", 64'(AWREADY), 64'd1);
    check("mid_rel_arready", 64'(ARREADY), 64'd1);
    check("mid_rel_wready",  64'(WREADY),  64'd0);
    read_burst(28'h20, 1, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
